// File: rtl/alu_pkg.sv
// Shared ALU opcodes, requester IDs and the request payload used by the ALU arbiter.
package alu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 3;

    localparam logic [OP_W-1:0] ALU_ADD = 3'b010;
    localparam logic [OP_W-1:0] ALU_SUB = 3'b110;
    localparam logic [OP_W-1:0] ALU_AND = 3'b000;
    localparam logic [OP_W-1:0] ALU_OR  = 3'b001;
    localparam logic [OP_W-1:0] ALU_SLT = 3'b111;

    localparam logic REQ_EX = 1'b0;
    localparam logic REQ_BR = 1'b1;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
    } alu_req_t;

    function automatic logic isLegalOp(input logic [OP_W-1:0] op);
        logic legal;
        case (op)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: legal = 1'b1;
            default:                                    legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way combinational grant: round-robin against last_grant, or requester 0 first.
module rr_arbiter2
    import alu_pkg::*;
#(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic elig0,
    input  logic elig1,
    input  logic last_grant,
    output logic grant0_c,
    output logic grant1_c
);

    always_comb begin
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        if (elig0 && elig1) begin
            // On a conflict the requester not served last wins, unless priority is fixed.
            if (FIXED_PRIORITY || last_grant == REQ_BR) begin
                grant0_c = 1'b1;
            end else begin
                grant1_c = 1'b1;
            end
        end else begin
            grant0_c = elig0;
            grant1_c = elig1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between the EX stage (0) and the branch unit (1):
// arbitrate, register the winner into an issue stage, capture the result into a per-requester slot.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              reqValid0,
    input  logic              reqValid1,
    output logic              reqReady0,
    output logic              reqReady1,
    input  logic [DATA_W-1:0] reqA0,
    input  logic [DATA_W-1:0] reqB0,
    input  logic [DATA_W-1:0] reqA1,
    input  logic [DATA_W-1:0] reqB1,
    input  logic [OP_W-1:0]   reqOp0,
    input  logic [OP_W-1:0]   reqOp1,

    output logic              rspValid0,
    output logic              rspValid1,
    input  logic              rspReady0,
    input  logic              rspReady1,
    output logic [DATA_W-1:0] rspResult0,
    output logic [DATA_W-1:0] rspResult1,
    output logic              rspZero0,
    output logic              rspZero1,
    output logic              rspIllegal0,
    output logic              rspIllegal1,

    output logic [DATA_W-1:0] aluIn1,
    output logic [DATA_W-1:0] aluIn2,
    output logic [OP_W-1:0]   aluControl,
    input  logic [DATA_W-1:0] aluResult,
    input  logic              aluZero
);

    logic              s1_valid;
    logic              s1_id;
    logic              s1_illegal;
    logic              last_grant;

    logic              elig0;
    logic              elig1;
    logic              grant0;
    logic              grant1;
    alu_req_t          win_req;
    logic              win_legal;
    logic [DATA_W-1:0] cap_result;
    logic              cap_zero;

    // A requester may go only if it has no op in flight and its response slot is free or draining.
    always_comb begin
        elig0 = reqValid0 && !reset && !(s1_valid && s1_id == REQ_EX) && (!rspValid0 || rspReady0);
        elig1 = reqValid1 && !reset && !(s1_valid && s1_id == REQ_BR) && (!rspValid1 || rspReady1);
    end

    rr_arbiter2 #(
        .FIXED_PRIORITY (FIXED_PRIORITY)
    ) u_arb (
        .elig0      (elig0),
        .elig1      (elig1),
        .last_grant (last_grant),
        .grant0_c   (grant0),
        .grant1_c   (grant1)
    );

    assign reqReady0 = grant0;
    assign reqReady1 = grant1;

    always_comb begin
        win_req.a  = grant1 ? reqA1  : reqA0;
        win_req.b  = grant1 ? reqB1  : reqB0;
        win_req.op = grant1 ? reqOp1 : reqOp0;
        win_legal  = isLegalOp(win_req.op);
    end

    // Issue stage: illegal ops are replaced by a harmless add of zeros.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_id      <= REQ_EX;
            s1_illegal <= 1'b0;
            last_grant <= REQ_BR;
            aluIn1     <= '0;
            aluIn2     <= '0;
            aluControl <= ALU_ADD;
        end else if (grant0 || grant1) begin
            s1_valid   <= 1'b1;
            s1_id      <= grant1;
            s1_illegal <= !win_legal;
            last_grant <= grant1;
            aluIn1     <= win_legal ? win_req.a  : '0;
            aluIn2     <= win_legal ? win_req.b  : '0;
            aluControl <= win_legal ? win_req.op : ALU_ADD;
        end else begin
            s1_valid   <= 1'b0;
        end
    end

    always_comb begin
        cap_result = s1_illegal ? '0 : aluResult;
        cap_zero   = s1_illegal | aluZero;
    end

    // Response slots: a capture in the same cycle as a consume keeps the new data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rspValid0   <= 1'b0;
            rspResult0  <= '0;
            rspZero0    <= 1'b0;
            rspIllegal0 <= 1'b0;
            rspValid1   <= 1'b0;
            rspResult1  <= '0;
            rspZero1    <= 1'b0;
            rspIllegal1 <= 1'b0;
        end else begin
            if (s1_valid && s1_id == REQ_EX) begin
                rspValid0   <= 1'b1;
                rspResult0  <= cap_result;
                rspZero0    <= cap_zero;
                rspIllegal0 <= s1_illegal;
            end else if (rspReady0) begin
                rspValid0   <= 1'b0;
            end

            if (s1_valid && s1_id == REQ_BR) begin
                rspValid1   <= 1'b1;
                rspResult1  <= cap_result;
                rspZero1    <= cap_zero;
                rspIllegal1 <= s1_illegal;
            end else if (rspReady1) begin
                rspValid1   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: round-robin (d0) and fixed-priority (d1) instances share stimulus,
// each checked every cycle against a transaction-level model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] req_a [2];
    logic [31:0] req_b [2];
    logic [2:0]  req_op [2];

    logic [1:0]  req_ready [2];
    logic [1:0]  rsp_valid [2];
    logic [1:0]  rsp_zero [2];
    logic [1:0]  rsp_ill [2];
    logic [31:0] rsp_res [2][2];
    logic [31:0] alu_in1 [2];
    logic [31:0] alu_in2 [2];
    logic [2:0]  alu_ctl [2];
    logic [31:0] alu_res [2];
    logic        alu_zero [2];

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b111:  return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic legal_op(input logic [2:0] op);
        return op inside {3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    endfunction

    for (genvar d = 0; d < 2; d++) begin : g_dut
        alu_arbiter #(.FIXED_PRIORITY(d == 1)) u_dut (
            .clk         (clk),
            .reset       (reset),
            .reqValid0   (req_valid[0]),
            .reqValid1   (req_valid[1]),
            .reqReady0   (req_ready[d][0]),
            .reqReady1   (req_ready[d][1]),
            .reqA0       (req_a[0]),
            .reqB0       (req_b[0]),
            .reqA1       (req_a[1]),
            .reqB1       (req_b[1]),
            .reqOp0      (req_op[0]),
            .reqOp1      (req_op[1]),
            .rspValid0   (rsp_valid[d][0]),
            .rspValid1   (rsp_valid[d][1]),
            .rspReady0   (rsp_ready[0]),
            .rspReady1   (rsp_ready[1]),
            .rspResult0  (rsp_res[d][0]),
            .rspResult1  (rsp_res[d][1]),
            .rspZero0    (rsp_zero[d][0]),
            .rspZero1    (rsp_zero[d][1]),
            .rspIllegal0 (rsp_ill[d][0]),
            .rspIllegal1 (rsp_ill[d][1]),
            .aluIn1      (alu_in1[d]),
            .aluIn2      (alu_in2[d]),
            .aluControl  (alu_ctl[d]),
            .aluResult   (alu_res[d]),
            .aluZero     (alu_zero[d])
        );
        assign alu_res[d]  = ref_alu(alu_ctl[d], alu_in1[d], alu_in2[d]);
        assign alu_zero[d] = (alu_res[d] == 32'd0);
    end

    // Reference model: in-flight ops tagged with their accept cycle, plus expected slot contents.
    typedef struct {
        int          d;
        int          id;
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          acc;
    } op_t;

    op_t         inflight [$];
    logic        m_last [2];
    logic [1:0]  m_sv [2];
    logic [1:0]  m_sz [2];
    logic [1:0]  m_si [2];
    logic [31:0] m_sr [2][2];
    logic [31:0] m_in1 [2];
    logic [31:0] m_in2 [2];
    logic [2:0]  m_ctl [2];
    int          obs_grant [2];
    int          cyc;
    int          n_cmp;
    int          n_mis;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset(input int d);
        for (int i = inflight.size() - 1; i >= 0; i--) begin
            if (inflight[i].d == d) inflight.delete(i);
        end
        m_sv[d] = 2'b00;
        m_sz[d] = 2'b00;
        m_si[d] = 2'b00;
        m_sr[d][0] = 32'd0;
        m_sr[d][1] = 32'd0;
        m_in1[d] = 32'd0;
        m_in2[d] = 32'd0;
        m_ctl[d] = 3'b010;
        m_last[d] = 1'b1;
    endtask

    // One clock cycle: check combinational grants, advance the model, check registered outputs.
    task automatic run_cycle();
        logic e [2];
        logic busy;
        logic [1:0] cap;
        int g;
        op_t o;
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 2; n++) begin
                busy = 1'b0;
                foreach (inflight[i]) begin
                    if (inflight[i].d == d && inflight[i].id == n && inflight[i].acc == cyc - 1) busy = 1'b1;
                end
                e[n] = req_valid[n] && !reset && !busy && (!m_sv[d][n] || rsp_ready[n]);
            end
            g = -1;
            if (e[0] && e[1])  g = (d == 1 || m_last[d]) ? 0 : 1;
            else if (e[0])     g = 0;
            else if (e[1])     g = 1;
            obs_grant[d] = req_ready[d][1] ? 1 : (req_ready[d][0] ? 0 : -1);
            check($sformatf("req_ready d%0d", d), 32'(req_ready[d]), (g == 0) ? 32'd1 : (g == 1) ? 32'd2 : 32'd0);

            if (reset) begin
                model_reset(d);
            end else begin
                cap = 2'b00;
                for (int i = inflight.size() - 1; i >= 0; i--) begin
                    if (inflight[i].d == d && inflight[i].acc == cyc - 1) begin
                        m_sv[d][inflight[i].id] = 1'b1;
                        m_sr[d][inflight[i].id] = inflight[i].res;
                        m_sz[d][inflight[i].id] = inflight[i].zero;
                        m_si[d][inflight[i].id] = inflight[i].ill;
                        cap[inflight[i].id] = 1'b1;
                        inflight.delete(i);
                    end
                end
                for (int n = 0; n < 2; n++) begin
                    if (!cap[n] && rsp_ready[n]) m_sv[d][n] = 1'b0;
                end
                if (g >= 0) begin
                    o.d = d; o.id = g; o.acc = cyc;
                    if (legal_op(req_op[g])) begin
                        o.res = ref_alu(req_op[g], req_a[g], req_b[g]);
                        o.zero = (o.res == 32'd0);
                        o.ill = 1'b0;
                        m_in1[d] = req_a[g];
                        m_in2[d] = req_b[g];
                        m_ctl[d] = req_op[g];
                    end else begin
                        o.res = 32'd0; o.zero = 1'b1; o.ill = 1'b1;
                        m_in1[d] = 32'd0;
                        m_in2[d] = 32'd0;
                        m_ctl[d] = 3'b010;
                    end
                    inflight.push_back(o);
                    m_last[d] = (g == 1);
                end
            end
        end

        @(posedge clk);
        cyc++;
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 2; n++) begin
                check($sformatf("rsp_valid d%0d r%0d", d, n), 32'(rsp_valid[d][n]), 32'(m_sv[d][n]));
                check($sformatf("rsp_result d%0d r%0d", d, n), rsp_res[d][n], m_sr[d][n]);
                check($sformatf("rsp_zero d%0d r%0d", d, n), 32'(rsp_zero[d][n]), 32'(m_sz[d][n]));
                check($sformatf("rsp_illegal d%0d r%0d", d, n), 32'(rsp_ill[d][n]), 32'(m_si[d][n]));
            end
            check($sformatf("alu_in1 d%0d", d), alu_in1[d], m_in1[d]);
            check($sformatf("alu_in2 d%0d", d), alu_in2[d], m_in2[d]);
            check($sformatf("alu_ctl d%0d", d), 32'(alu_ctl[d]), 32'(m_ctl[d]));
        end
    endtask

    task automatic set_req(input int n, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        req_a[n] = a;
        req_b[n] = b;
        req_op[n] = op;
    endtask

    localparam logic [2:0] LEGAL_OPS [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

    initial begin
        n_cmp = 0;
        n_mis = 0;
        cyc = 0;
        reset = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        set_req(0, 32'd0, 32'd0, 3'b010);
        set_req(1, 32'd0, 32'd0, 3'b010);
        model_reset(0);
        model_reset(1);

        repeat (2) run_cycle();
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset rsp_valid d%0d", d), 32'(rsp_valid[d]), 32'd0);
            check($sformatf("reset alu_ctl d%0d", d), 32'(alu_ctl[d]), 32'h2);
        end

        // Single add on requester 0: response two cycles after accept.
        req_valid = 2'b01;
        set_req(0, 32'd5, 32'd7, 3'b010);
        run_cycle();
        for (int d = 0; d < 2; d++) check($sformatf("single grant d%0d", d), 32'(obs_grant[d]), 32'd0);
        req_valid = 2'b00;
        run_cycle();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("single rsp_valid d%0d", d), 32'(rsp_valid[d]), 32'd1);
            check($sformatf("single result d%0d", d), rsp_res[d][0], 32'd12);
            check($sformatf("single zero d%0d", d), 32'(rsp_zero[d][0]), 32'd0);
        end
        rsp_ready = 2'b11;
        run_cycle();

        // Both requesters continuously valid: grants interleave starting with requester 0.
        reset = 1'b1;
        run_cycle();
        reset = 1'b0;
        req_valid = 2'b11;
        set_req(0, 32'd9, 32'd9, 3'b110);
        set_req(1, 32'd3, 32'd4, 3'b111);
        for (int k = 0; k < 8; k++) begin
            run_cycle();
            for (int d = 0; d < 2; d++) check($sformatf("alternate grant d%0d k%0d", d, k), 32'(obs_grant[d]), 32'(k % 2));
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("sub result d%0d", d), rsp_res[d][0], 32'd0);
            check($sformatf("sub zero d%0d", d), 32'(rsp_zero[d][0]), 32'd1);
            check($sformatf("slt result d%0d", d), rsp_res[d][1], 32'd1);
            check($sformatf("slt zero d%0d", d), 32'(rsp_zero[d][1]), 32'd0);
        end

        // Requester 1 backpressured by its own full slot, then released for one cycle.
        req_valid = 2'b10;
        rsp_ready = 2'b01;
        set_req(1, 32'd100, 32'd1, 3'b010);
        for (int k = 0; k < 6; k++) begin
            run_cycle();
            for (int d = 0; d < 2; d++) check($sformatf("blocked ready d%0d", d), 32'(obs_grant[d]), 32'hFFFF_FFFF);
        end
        set_req(1, 32'd200, 32'd1, 3'b010);
        rsp_ready = 2'b11;
        run_cycle();
        for (int d = 0; d < 2; d++) check($sformatf("release grant d%0d", d), 32'(obs_grant[d]), 32'd1);
        rsp_ready = 2'b01;
        req_valid = 2'b00;
        repeat (2) run_cycle();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("release rsp_valid d%0d", d), 32'(rsp_valid[d][1]), 32'd1);
            check($sformatf("release result d%0d", d), rsp_res[d][1], 32'd201);
        end

        // Illegal opcode is substituted with add 0,0 and flagged.
        rsp_ready = 2'b00;
        req_valid = 2'b01;
        set_req(0, 32'hFFFF_FFFF, 32'd12345, 3'b011);
        run_cycle();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("illegal alu_ctl d%0d", d), 32'(alu_ctl[d]), 32'h2);
            check($sformatf("illegal alu_in1 d%0d", d), alu_in1[d], 32'd0);
            check($sformatf("illegal alu_in2 d%0d", d), alu_in2[d], 32'd0);
        end
        req_valid = 2'b00;
        run_cycle();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("illegal rsp_valid d%0d", d), 32'(rsp_valid[d][0]), 32'd1);
            check($sformatf("illegal result d%0d", d), rsp_res[d][0], 32'd0);
            check($sformatf("illegal zero d%0d", d), 32'(rsp_zero[d][0]), 32'd1);
            check($sformatf("illegal flag d%0d", d), 32'(rsp_ill[d][0]), 32'd1);
        end

        // Reset one cycle after an accept discards the op.
        rsp_ready = 2'b11;
        req_valid = 2'b01;
        set_req(0, 32'd1, 32'd1, 3'b010);
        run_cycle();
        req_valid = 2'b00;
        reset = 1'b1;
        run_cycle();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            run_cycle();
            for (int d = 0; d < 2; d++) begin
                check($sformatf("post-reset rsp_valid d%0d", d), 32'(rsp_valid[d]), 32'd0);
                check($sformatf("post-reset rsp_illegal d%0d", d), 32'(rsp_ill[d]), 32'd0);
                check($sformatf("post-reset alu_in1 d%0d", d), alu_in1[d], 32'd0);
            end
        end

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 199) == 0);
            req_valid = 2'($urandom);
            rsp_ready = 2'($urandom_range(0, 3) == 0 ? 0 : $urandom);
            for (int n = 0; n < 2; n++) begin
                req_op[n] = ($urandom_range(0, 4) == 0) ? 3'($urandom) : LEGAL_OPS[$urandom_range(0, 4)];
                req_a[n] = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
                req_b[n] = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
            end
            run_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
